// File: rtl/edge_debounce.sv
// Debounces an already-synchronized level, emits registered edge pulses and,
// when EDGE_COUNT_EN is defined, a saturating count of accepted rising edges.
module edge_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_in,
    input  logic             cnt_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int TMR_W = $clog2(DEB_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEB_CYCLES - 1);

    // Bit 1 of the encoding is the debounced level, so level_out is a flop output.
    localparam logic [1:0] ST_LOW   = 2'b00;
    localparam logic [1:0] ST_CHK_H = 2'b01;
    localparam logic [1:0] ST_HIGH  = 2'b11;
    localparam logic [1:0] ST_CHK_L = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (sync_in) begin
                    state_d = ST_CHK_H;
                    tmr_d   = '0;
                end
            end
            ST_CHK_H: begin
                if (!sync_in) begin
                    state_d = ST_LOW;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_HIGH;
                    tmr_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_HIGH: begin
                if (!sync_in) begin
                    state_d = ST_CHK_L;
                    tmr_d   = '0;
                end
            end
            ST_CHK_L: begin
                if (sync_in) begin
                    state_d = ST_HIGH;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_LOW;
                    tmr_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOW;
            tmr_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out  = state_q[1];
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef EDGE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a coincident increment; the count holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (rise_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign event_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign event_cnt      = '0;
`endif

endmodule

// File: tb/tb_edge_debounce.sv
// Directed bench for edge_debounce: vector table plus saturation sequence.
// Expected event counts are forced to 0 unless EDGE_COUNT_EN is defined.
module tb_edge_debounce;

`ifdef EDGE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       sync_in;
    logic       cnt_clr;
    logic       level_out, rise_pulse, fall_pulse;
    logic [7:0] event_cnt;
    logic       s_level_out, s_rise_pulse, s_fall_pulse;
    logic [1:0] s_event_cnt;

    edge_debounce #(.DEB_CYCLES(4), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sync_in   (sync_in),
        .cnt_clr   (cnt_clr),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .event_cnt (event_cnt)
    );

    edge_debounce #(.DEB_CYCLES(4), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .sync_in   (sync_in),
        .cnt_clr   (cnt_clr),
        .level_out (s_level_out),
        .rise_pulse(s_rise_pulse),
        .fall_pulse(s_fall_pulse),
        .event_cnt (s_event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit r;
        bit s;
        bit c;
        bit lvl;
        bit ri;
        bit fa;
        int cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    function automatic void add(bit r, bit s, bit c, bit lvl, bit ri, bit fa, int cnt);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.lvl = lvl; v.ri = ri; v.fa = fa; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit c);
        rst = r; sync_in = s; cnt_clr = c;
        @(posedge clk);
        #1;
    endtask

    function automatic int ecnt(input int c);
        return CNT_EN ? c : 0;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; sync_in = 1'b0; cnt_clr = 1'b0;

        // reset, then a clean rise accepted on the 5th sample
        add(1,0,0, 0,0,0, 0);  add(1,0,0, 0,0,0, 0);
        add(0,1,0, 0,0,0, 0);  add(0,1,0, 0,0,0, 0);
        add(0,1,0, 0,0,0, 0);  add(0,1,0, 0,0,0, 0);
        add(0,1,0, 1,1,0, 0);  add(0,1,0, 1,0,0, 1);
        // 3-cycle low glitch is rejected, then a real fall
        add(0,0,0, 1,0,0, 1);  add(0,0,0, 1,0,0, 1);
        add(0,0,0, 1,0,0, 1);  add(0,1,0, 1,0,0, 1);
        add(0,0,0, 1,0,0, 1);  add(0,0,0, 1,0,0, 1);
        add(0,0,0, 1,0,0, 1);  add(0,0,0, 1,0,0, 1);
        add(0,0,0, 0,0,1, 1);  add(0,0,0, 0,0,0, 1);
        // interrupted rise discards timer credit
        add(0,1,0, 0,0,0, 1);  add(0,1,0, 0,0,0, 1);
        add(0,1,0, 0,0,0, 1);  add(0,0,0, 0,0,0, 1);
        add(0,1,0, 0,0,0, 1);  add(0,1,0, 0,0,0, 1);
        add(0,1,0, 0,0,0, 1);  add(0,1,0, 0,0,0, 1);
        add(0,1,0, 1,1,0, 1);  add(0,1,0, 1,0,0, 2);
        // fall, rise again, clear coincident with rise_pulse
        add(0,0,0, 1,0,0, 2);  add(0,0,0, 1,0,0, 2);
        add(0,0,0, 1,0,0, 2);  add(0,0,0, 1,0,0, 2);
        add(0,0,0, 0,0,1, 2);  add(0,1,0, 0,0,0, 2);
        add(0,1,0, 0,0,0, 2);  add(0,1,0, 0,0,0, 2);
        add(0,1,0, 0,0,0, 2);  add(0,1,0, 1,1,0, 2);
        add(0,1,1, 1,0,0, 0);  add(0,1,0, 1,0,0, 0);
        // reset in CHK_H with timer=2, then full debounce after release
        add(0,0,0, 1,0,0, 0);  add(0,0,0, 1,0,0, 0);
        add(0,0,0, 1,0,0, 0);  add(0,0,0, 1,0,0, 0);
        add(0,0,0, 0,0,1, 0);  add(0,1,0, 0,0,0, 0);
        add(0,1,0, 0,0,0, 0);  add(0,1,0, 0,0,0, 0);
        add(1,1,0, 0,0,0, 0);  add(0,1,0, 0,0,0, 0);
        add(0,1,0, 0,0,0, 0);  add(0,1,0, 0,0,0, 0);
        add(0,1,0, 0,0,0, 0);  add(0,1,0, 1,1,0, 0);
        add(0,1,0, 1,0,0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].c);
            check("level_out",    i, int'(level_out),  int'(vecs[i].lvl));
            check("rise_pulse",   i, int'(rise_pulse), int'(vecs[i].ri));
            check("fall_pulse",   i, int'(fall_pulse), int'(vecs[i].fa));
            check("event_cnt",    i, int'(event_cnt),  ecnt(vecs[i].cnt));
            check("sat_event_cnt", i, int'(s_event_cnt), ecnt(vecs[i].cnt));
            check("pulse_overlap", i, int'(rise_pulse & fall_pulse), 0);
        end

        // saturation: 5 clean rises, CNT_W=2 must stick at 3
        step(1, 0, 0);
        step(1, 0, 0);
        check("rst_cnt", 100, int'(event_cnt), 0);
        check("rst_sat_cnt", 100, int'(s_event_cnt), 0);
        for (int k = 1; k <= 5; k++) begin
            for (int j = 1; j <= 5; j++) begin
                step(0, 1, 0);
                if (j == 4) check("sat_early_rise", 100 + k, int'(s_rise_pulse), 0);
            end
            check("sat_rise", 100 + k, int'(s_rise_pulse), 1);
            check("sat_level", 100 + k, int'(s_level_out), 1);
            step(0, 1, 0);
            check("sat_cnt", 100 + k, int'(s_event_cnt), ecnt(k > 3 ? 3 : k));
            check("wide_cnt", 100 + k, int'(event_cnt), ecnt(k));
            for (int j = 1; j <= 5; j++) step(0, 0, 0);
            check("sat_fall", 100 + k, int'(s_fall_pulse), 1);
        end

        // clear while saturated and idle
        step(0, 0, 1);
        check("clr_sat_cnt", 200, int'(s_event_cnt), 0);
        check("clr_wide_cnt", 200, int'(event_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/edge_debounce.md
EDGE_DEBOUNCE -- requirements
Module: edge_debounce

Interface
REQ-001 Parameter DEB_CYCLES, default 4: number of extra consecutive cycles sync_in must hold a new level before it is accepted; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of event_cnt.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sync_in  input  1  level already synchronized into the clk domain by the upstream metastability stage.
REQ-006 cnt_clr  input  1  synchronous clear of event_cnt.
REQ-007 level_out  output  1  debounced level, registered.
REQ-008 rise_pulse  output  1  one-cycle pulse on accepted 0->1 transition, registered.
REQ-009 fall_pulse  output  1  one-cycle pulse on accepted 1->0 transition, registered.
REQ-010 event_cnt  output  CNT_W  count of accepted rising transitions, registered.

Function
REQ-011 The block SHALL implement a four-state FSM: LOW, CHK_H, HIGH, CHK_L, with an internal timer of ceil(log2(DEB_CYCLES+1)) bits.
REQ-012 LOW: sync_in=1 -> CHK_H with timer=0; otherwise stay in LOW.
REQ-013 CHK_H: sync_in=0 -> LOW (glitch rejected, no pulse); sync_in=1 and timer<DEB_CYCLES-1 -> timer+1; sync_in=1 and timer=DEB_CYCLES-1 -> HIGH.
REQ-014 HIGH and CHK_L SHALL mirror LOW and CHK_H with the polarity of sync_in inverted.
REQ-015 level_out SHALL be 1 exactly when the state is HIGH or CHK_L.
REQ-016 Latency: level_out SHALL change on the edge that samples the new level for the (DEB_CYCLES+1)th consecutive time; for DEB_CYCLES=4, five consecutive samples.
REQ-017 rise_pulse SHALL be 1 for exactly the one cycle following the CHK_H->HIGH transition; fall_pulse likewise for CHK_L->LOW; the two SHALL never be high together.
REQ-018 Any interruption of the candidate level SHALL discard the accumulated timer value; no partial credit.
REQ-019 event_cnt SHALL increment by 1 on each cycle in which rise_pulse is asserted.
REQ-020 event_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-021 When cnt_clr=1, event_cnt SHALL be 0 on the next cycle; cnt_clr SHALL take priority over a simultaneous increment.

Reset
REQ-022 On rst=1 at a clk edge: state=LOW, timer=0, level_out=0, rise_pulse=0, fall_pulse=0, event_cnt=0.
REQ-023 Reset asserted mid-debounce SHALL abandon the check with no pulse; after release the FSM SHALL start from LOW regardless of sync_in.
REQ-024 If sync_in=1 at reset release, a full debounce (REQ-016) SHALL complete before rise_pulse and level_out=1.

Configuration
REQ-025 Macro EDGE_COUNT_EN: when defined, the event counter of REQ-019..021 SHALL be present.
REQ-026 When EDGE_COUNT_EN is undefined, no counter registers SHALL be synthesized, event_cnt SHALL be constant 0, and cnt_clr SHALL be ignored; all other behaviour SHALL be unchanged.

Verification
REQ-027 DEB_CYCLES=4, rst high 2 cycles then sync_in=1 held -> level_out=1 and a single rise_pulse on the 5th edge after sync_in goes high; event_cnt=1 (EDGE_COUNT_EN).
REQ-028 From HIGH, sync_in=0 for 3 cycles then back to 1 -> no fall_pulse, level_out stays 1; then sync_in=0 held for 5 cycles -> fall_pulse once, level_out=0.
REQ-029 CNT_W=2, 5 clean rising transitions -> event_cnt reads 1,2,3,3,3 (saturation).
REQ-030 cnt_clr asserted in the same cycle as rise_pulse, with event_cnt=2 -> event_cnt=0 next cycle.
REQ-031 rst asserted while in CHK_H with timer=2 -> outputs 0, no pulse; after release with sync_in=1, rise_pulse occurs after 5 further edges.
REQ-032 Build without EDGE_COUNT_EN, repeat REQ-027 -> same level_out/rise_pulse timing, event_cnt constant 0.
